// File: rtl/memory_controller_if.sv
// memory_controller_if: RAM port plus fetch and load/store request buses of the memory controller
interface memory_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  readyIn;
  logic                  clearIn;
  logic [7:0]            ramDataIn;
  logic [7:0]            ramDataOut;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic                  ramWrite;
  logic                  ioBufferFull;
  logic                  fetchFlag;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic                  fetchOkFlag;
  logic [31:0]           fetchData;
  logic                  lsbFlag;
  logic [2:0]            lsbOp;
  logic [ADDR_WIDTH-1:0] lsbAddr;
  logic [31:0]           lsbDataIn;
  logic [31:0]           lsbDataOut;
  logic                  lsbOkFlag;
  modport master (
    input  readyIn, clearIn, ramDataIn, ioBufferFull, fetchFlag, fetchAddr,
           lsbFlag, lsbOp, lsbAddr, lsbDataIn,
    output ramDataOut, ramAddr, ramWrite, fetchOkFlag, fetchData, lsbDataOut, lsbOkFlag
  );
  modport slave (
    output readyIn, clearIn, ramDataIn, ioBufferFull, fetchFlag, fetchAddr,
           lsbFlag, lsbOp, lsbAddr, lsbDataIn,
    input  ramDataOut, ramAddr, ramWrite, fetchOkFlag, fetchData, lsbDataOut, lsbOkFlag
  );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: arbitrates fetch and load/store onto a byte-wide RAM, one byte per cycle,
// little-endian assembly, one-cycle OK pulse to the granted requester.
module memory_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_MASK_HI = 17
) (
  input logic clockIn,
  input logic resetIn,
  memory_controller_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2;
  logic [1:0]            state_q;
  logic [2:0]            cnt_q, n_q, n_d, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, data_q, data_d, fetch_data_q, lsb_data_q;
  logic [7:0]            dout_q;
  logic [1:0]            k;
  logic                  wr_q, fetch_ok_q, lsb_ok_q, owner_q, last_grant_q;
  logic                  cand_f, cand_l, grant_l, stall;
  always_comb begin
    cand_f  = bus.fetchFlag & ~fetch_ok_q;
    cand_l  = bus.lsbFlag & ~lsb_ok_q;
    grant_l = cand_l & (~cand_f | ~last_grant_q);
    n_d     = (~grant_l | bus.lsbOp[1]) ? 3'd4 : bus.lsbOp[0] ? 3'd2 : 3'd1;
    stall   = addr_q[IO_MASK_HI -: 2] == 2'b11 && bus.ioBufferFull;
    nxt     = cnt_q + 3'd1;
    k       = cnt_q[1:0] - 2'd1;
    data_d  = data_q;
    data_d[{k, 3'b000} +: 8] = bus.ramDataIn;
  end
  assign bus.ramAddr     = addr_q;
  assign bus.ramDataOut  = dout_q;
  assign bus.ramWrite    = wr_q & bus.readyIn & ~stall;
  assign bus.fetchOkFlag = fetch_ok_q;
  assign bus.lsbOkFlag   = lsb_ok_q;
  assign bus.fetchData   = fetch_data_q;
  assign bus.lsbDataOut  = lsb_data_q;
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      dout_q       <= '0;
      wr_q         <= 1'b0;
      fetch_ok_q   <= 1'b0;
      lsb_ok_q     <= 1'b0;
      fetch_data_q <= '0;
      lsb_data_q   <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else if (bus.readyIn) begin
      fetch_ok_q <= 1'b0;
      lsb_ok_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (!bus.clearIn && (cand_f || cand_l)) begin
          owner_q      <= grant_l;
          last_grant_q <= grant_l;
          n_q          <= n_d;
          cnt_q        <= '0;
          addr_q       <= grant_l ? bus.lsbAddr : bus.fetchAddr;
          wdata_q      <= bus.lsbDataIn;
          data_q       <= '0;
          dout_q       <= bus.lsbDataIn[7:0];
          wr_q         <= grant_l & bus.lsbOp[2];
          state_q      <= (grant_l & bus.lsbOp[2]) ? WRITE : READ;
        end
      end else if (state_q == READ) begin
        // read data trails its address by two edges, so capture runs one index behind cnt
        if (bus.clearIn) state_q <= IDLE;
        else begin
          cnt_q <= nxt;
          if (nxt < n_q) addr_q <= addr_q + ADDR_WIDTH'(1);
          if (cnt_q != 3'd0) data_q <= data_d;
          if (cnt_q == n_q) begin
            state_q <= IDLE;
            if (owner_q) begin
              lsb_data_q <= data_d;
              lsb_ok_q   <= 1'b1;
            end else begin
              fetch_data_q <= data_d;
              fetch_ok_q   <= 1'b1;
            end
          end
        end
      end else if (!stall) begin
        if (nxt == n_q) begin
          wr_q     <= 1'b0;
          lsb_ok_q <= 1'b1;
          state_q  <= IDLE;
        end else begin
          cnt_q  <= nxt;
          addr_q <= addr_q + ADDR_WIDTH'(1);
          dout_q <= 8'(wdata_q >> {nxt[1:0], 3'b000});
        end
      end
    end
  end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed vectors plus hand sequences for arbitration, flush, I/O stall, freeze and reset
module tb_memory_controller;
  typedef struct {
    bit          f;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
    int          nwr;
  } vec_t;
  logic clk, rst, init;
  logic [7:0] mem [0:262143];
  int n_chk, n_fail, wr_cnt, w0, okc;
  vec_t vecs [12];
  memory_controller_if #(.ADDR_WIDTH(32)) bus ();
  memory_controller #(.ADDR_WIDTH(32), .IO_MASK_HI(17)) dut (
    .clockIn(clk), .resetIn(rst), .bus(bus.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // byte RAM with registered read, frozen together with the controller
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 262144; i++) mem[i] <= 8'h00;
      mem[18'h00100] <= 8'h13; mem[18'h00101] <= 8'h05;
      mem[18'h00200] <= 8'h11; mem[18'h00201] <= 8'h22;
      mem[18'h00202] <= 8'h33; mem[18'h00203] <= 8'h44;
      mem[18'h3FFFF] <= 8'hAA; mem[18'h00000] <= 8'hBB;
      mem[18'h00001] <= 8'hCC; mem[18'h00002] <= 8'hDD;
    end else if (bus.readyIn) begin
      bus.ramDataIn <= mem[bus.ramAddr[17:0]];
      if (bus.ramWrite) mem[bus.ramAddr[17:0]] <= bus.ramDataOut;
    end
  end
  initial wr_cnt = 0;
  always @(posedge clk) if (bus.ramWrite === 1'b1) wr_cnt <= wr_cnt + 1;
  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_ok(input bit l, input int exp, input string nm);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(l ? bus.lsbOkFlag : bus.fetchOkFlag) && c < 40);
    if (l) bus.lsbFlag = 1'b0;
    else bus.fetchFlag = 1'b0;
    check(32'(c), 32'(exp), {nm, "_latency"});
  endtask
  task automatic req(input bit f, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    if (f) begin
      bus.fetchAddr = a;
      bus.fetchFlag = 1'b1;
    end else begin
      bus.lsbOp     = op;
      bus.lsbAddr   = a;
      bus.lsbDataIn = d;
      bus.lsbFlag   = 1'b1;
    end
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    int w;
    w = wr_cnt;
    req(v.f, v.op, v.addr, v.wdata);
    wait_ok(!v.f, v.lat, nm);
    if (v.f || !v.op[2]) check(v.f ? bus.fetchData : bus.lsbDataOut, v.exp, {nm, "_data"});
    check(32'(wr_cnt - w), 32'(v.nwr), {nm, "_writes"});
    @(negedge clk);
    check({31'b0, v.f ? bus.fetchOkFlag : bus.lsbOkFlag}, 32'd0, {nm, "_pulse"});
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    vecs[0]  = '{1'b1, 3'b011, 32'h0000_0100, 32'h0, 32'h0000_0513, 6, 0};
    vecs[1]  = '{1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'h4433_2211, 6, 0};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h0000_0044, 3, 0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0201, 32'h0, 32'h0000_3322, 4, 0};
    vecs[4]  = '{1'b0, 3'b100, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 2, 1};
    vecs[5]  = '{1'b0, 3'b011, 32'h0000_0020, 32'h0, 32'h0000_00EF, 6, 0};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_0040, 32'h1234_5678, 32'h0, 3, 2};
    vecs[7]  = '{1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0000_5678, 6, 0};
    vecs[8]  = '{1'b0, 3'b111, 32'h0000_0050, 32'hCAFE_F00D, 32'h0, 5, 4};
    vecs[9]  = '{1'b1, 3'b011, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 6, 0};
    vecs[10] = '{1'b1, 3'b011, 32'hFFFF_FFFF, 32'h0, 32'hDDCC_BBAA, 6, 0};
    vecs[11] = '{1'b0, 3'b000, 32'h0003_FFFF, 32'h0, 32'h0000_00AA, 3, 0};
    rst = 1'b1; init = 1'b1;
    bus.readyIn = 1'b1; bus.clearIn = 1'b0; bus.ioBufferFull = 1'b0;
    bus.fetchFlag = 1'b0; bus.fetchAddr = '0;
    bus.lsbFlag = 1'b0; bus.lsbOp = '0; bus.lsbAddr = '0; bus.lsbDataIn = '0;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check({31'b0, bus.ramWrite}, 0, "rst_ramWrite");
    check(bus.ramAddr, 0, "rst_ramAddr");
    check({24'b0, bus.ramDataOut}, 0, "rst_ramDataOut");
    check({31'b0, bus.fetchOkFlag}, 0, "rst_fetchOk");
    check({31'b0, bus.lsbOkFlag}, 0, "rst_lsbOk");
    check(bus.fetchData, 0, "rst_fetchData");
    check(bus.lsbDataOut, 0, "rst_lsbDataOut");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    // word fetch: one address per cycle
    req(1'b1, 3'b011, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(bus.ramAddr, 32'h100 + 32'(i), $sformatf("seqA_addr%0d", i));
    end
    wait_ok(1'b0, 2, "seqA");
    check(bus.fetchData, 32'h513, "seqA_data");
    @(negedge clk);
    // freeze during a store byte suppresses the write strobe
    w0 = wr_cnt;
    req(1'b0, 3'b100, 32'h80, 32'h77);
    @(negedge clk);
    check({31'b0, bus.ramWrite}, 1, "frzw_we_on");
    bus.readyIn = 1'b0;
    #1 check({31'b0, bus.ramWrite}, 0, "frzw_we_forced");
    @(negedge clk);
    check({31'b0, bus.ramWrite}, 0, "frzw_we_held");
    bus.readyIn = 1'b1;
    wait_ok(1'b1, 1, "frzw");
    check(32'(wr_cnt - w0), 1, "frzw_writes");
    @(negedge clk);
    run_vec('{1'b0, 3'b000, 32'h80, 32'h0, 32'h77, 3, 0}, "frzw_rd");
    // clear in IDLE blocks the grant for that cycle
    bus.clearIn = 1'b1;
    req(1'b0, 3'b000, 32'h203, 32'h0);
    @(negedge clk);
    bus.clearIn = 1'b0;
    wait_ok(1'b1, 3, "clr_idle");
    check(bus.lsbDataOut, 32'h44, "clr_idle_data");
    @(negedge clk);
    // clear aborts a fetch read on its second byte
    req(1'b1, 3'b011, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.clearIn = 1'b1;
    bus.fetchFlag = 1'b0;
    @(negedge clk);
    bus.clearIn = 1'b0;
    check(bus.ramAddr, 32'h101, "clr_rd_addr");
    okc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.fetchOkFlag) okc++;
    end
    check(32'(okc), 0, "clr_rd_no_ok");
    run_vec('{1'b1, 3'b011, 32'h200, 32'h0, 32'h4433_2211, 6, 0}, "clr_rd_next");
    // clear does not disturb a committed store
    w0 = wr_cnt;
    req(1'b0, 3'b111, 32'h60, 32'h0102_0304);
    @(negedge clk);
    @(negedge clk);
    bus.clearIn = 1'b1;
    @(negedge clk);
    bus.clearIn = 1'b0;
    wait_ok(1'b1, 2, "clr_wr");
    check(32'(wr_cnt - w0), 4, "clr_wr_writes");
    @(negedge clk);
    run_vec('{1'b0, 3'b011, 32'h60, 32'h0, 32'h0102_0304, 6, 0}, "clr_wr_rd");
    // I/O store stalls while the buffer is full
    w0 = wr_cnt;
    bus.ioBufferFull = 1'b1;
    req(1'b0, 3'b100, 32'h3_0000, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({31'b0, bus.ramWrite}, 0, $sformatf("io_stall_we%0d", i));
      check(bus.ramAddr, 32'h3_0000, $sformatf("io_stall_addr%0d", i));
    end
    bus.ioBufferFull = 1'b0;
    #1 check({31'b0, bus.ramWrite}, 1, "io_release_we");
    check({24'b0, bus.ramDataOut}, 32'h5A, "io_release_byte");
    wait_ok(1'b1, 1, "io");
    check(32'(wr_cnt - w0), 1, "io_writes");
    @(negedge clk);
    run_vec('{1'b0, 3'b000, 32'h3_0000, 32'h0, 32'h5A, 3, 0}, "io_rd");
    // two frozen cycles in the middle of a word fetch
    req(1'b1, 3'b011, 32'h200, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check(bus.ramAddr, 32'h201, "frz_addr0");
    bus.readyIn = 1'b0;
    @(negedge clk);
    check(bus.ramAddr, 32'h201, "frz_addr1");
    @(negedge clk);
    check(bus.ramAddr, 32'h201, "frz_addr2");
    bus.readyIn = 1'b1;
    wait_ok(1'b0, 4, "frz");
    check(bus.fetchData, 32'h4433_2211, "frz_data");
    @(negedge clk);
    // reset after the second store byte is presented
    w0 = wr_cnt;
    req(1'b0, 3'b111, 32'h70, 32'hA1B2_C3D4);
    @(negedge clk);
    @(negedge clk);
    check(bus.ramAddr, 32'h71, "rstw_addr");
    check({24'b0, bus.ramDataOut}, 32'hC3, "rstw_byte");
    rst = 1'b1;
    bus.lsbFlag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check({31'b0, bus.ramWrite}, 0, "rstw_ramWrite");
    check(bus.ramAddr, 0, "rstw_ramAddr");
    check({24'b0, bus.ramDataOut}, 0, "rstw_ramDataOut");
    check({30'b0, bus.fetchOkFlag, bus.lsbOkFlag}, 0, "rstw_oks");
    check(bus.fetchData, 0, "rstw_fetchData");
    check(bus.lsbDataOut, 0, "rstw_lsbDataOut");
    check(32'(wr_cnt - w0), 2, "rstw_writes");
    run_vec('{1'b0, 3'b011, 32'h70, 32'h0, 32'h0000_C3D4, 6, 0}, "rstw_rd");
    run_vec('{1'b1, 3'b011, 32'h100, 32'h0, 32'h513, 6, 0}, "arb_prep");
    // round-robin: LSB wins after a fetch grant, then fetch after an LSB grant
    req(1'b1, 3'b011, 32'h100, 32'h0);
    req(1'b0, 3'b011, 32'h200, 32'h0);
    wait_ok(1'b1, 6, "arb_lsb1");
    check(bus.lsbDataOut, 32'h4433_2211, "arb_lsb1_data");
    req(1'b0, 3'b000, 32'h203, 32'h0);
    wait_ok(1'b0, 6, "arb_fetch1");
    check(bus.fetchData, 32'h513, "arb_fetch1_data");
    wait_ok(1'b1, 3, "arb_lsb2");
    check(bus.lsbDataOut, 32'h44, "arb_lsb2_data");
    @(negedge clk);
    req(1'b1, 3'b011, 32'h200, 32'h0);
    req(1'b0, 3'b001, 32'h100, 32'h0);
    wait_ok(1'b0, 6, "arb_fetch2");
    check(bus.fetchData, 32'h4433_2211, "arb_fetch2_data");
    wait_ok(1'b1, 4, "arb_lsb3");
    check(bus.lsbDataOut, 32'h513, "arb_lsb3_data");
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
